blockram_stream_reader: RTL

- Read-side sequencer for the 512x8 dual-clock block RAM buffer. Runs entirely in the RAM's read clock domain.
- Given a start address and byte count, it issues one-cycle-latency RAM reads. It presents the bytes as a valid/ready byte stream to a downstream serializer (SPI/SD transmit shifter).
- Absorbs the RAM read latency and downstream backpressure with a small prefetch FIFO. Sustains 1 byte/cycle.

---
 rtl/stream_reader_pkg.sv | 21 ++
 rtl/byte_prefetch_fifo.sv | 49 ++++
 rtl/blockram_stream_reader.sv | 116 +++++++++++
 3 files changed

// File: rtl/stream_reader_pkg.sv
// Shared constants, types and the CRC-16/XMODEM byte step for the block-RAM stream reader.
package stream_reader_pkg;
  localparam int ADDR_W     = 9;
  localparam int DATA_W     = 8;
  localparam int LEN_W      = 10;
  localparam int FIFO_DEPTH = 3;
  localparam logic [15:0] CRC16_POLY = 16'h1021;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [LEN_W-1:0]  len_t;
  typedef logic [DATA_W-1:0] byte_t;
  typedef enum logic {IDLE, STREAM} state_t;

  function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input byte_t data);
    logic [15:0] c;
    c = crc ^ {data, 8'h00};
    for (int i = 0; i < 8; i++)
      c = c[15] ? ((c << 1) ^ CRC16_POLY) : (c << 1);
    return c;
  endfunction
endpackage

// File: rtl/byte_prefetch_fifo.sv
// Small synchronous byte FIFO with flush; head is always presented, count tracks occupancy.
module byte_prefetch_fifo
  import stream_reader_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             push,
  input  byte_t            push_data,
  input  logic             pop,
  input  logic             flush,
  output byte_t            head,
  output logic [CNT_W-1:0] count
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  byte_t            mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != CNT_W'(DEPTH)) || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      rd_ptr <= wr_ptr;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= inc(wr_ptr);
      end
      if (do_pop) rd_ptr <= inc(rd_ptr);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end
endmodule

// File: rtl/blockram_stream_reader.sv
// Read sequencer: streams Length bytes from the block RAM starting at StartAddr as valid/ready bytes.
// Optional CRC-16/XMODEM of accepted bytes on Crc16 when STREAM_READER_CRC_EN is defined.
module blockram_stream_reader
  import stream_reader_pkg::*;
(
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
  input  addr_t       StartAddr,
  input  len_t        Length,
  input  logic        Abort,
  output logic        Busy,
  output logic        Done,
  output logic        RamReadEnable,
  output addr_t       RamReadAddr,
  input  byte_t       RamReadData,
  output logic        OutValid,
  output byte_t       OutData,
  input  logic        OutReady
`ifdef STREAM_READER_CRC_EN
  , output logic [15:0] Crc16
`endif
);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  state_t           state, state_nxt;
  addr_t            addr, addr_nxt;
  len_t             issue_rem, issue_nxt, pop_rem, pop_nxt;
  logic             inflight, done_nxt, issue, fire, accept;
  logic [CNT_W-1:0] fifo_count;

  // Credit counts the in-flight read so the FIFO can never overflow; registered terms only.
  assign issue  = (state == STREAM) && (issue_rem != '0) &&
                  ((int'(fifo_count) + int'(inflight)) < FIFO_DEPTH);
  assign fire   = OutValid && OutReady && !Abort;
  assign accept = (state == IDLE) && Start && !Abort;

  assign Busy          = (state == STREAM);
  assign RamReadEnable = issue;
  assign RamReadAddr   = addr;
  assign OutValid      = (fifo_count != '0);

  always_comb begin
    state_nxt = state;
    addr_nxt  = addr;
    issue_nxt = issue_rem;
    pop_nxt   = pop_rem;
    done_nxt  = 1'b0;
    case (state)
      IDLE: if (accept) begin
        addr_nxt  = StartAddr;
        issue_nxt = Length;
        pop_nxt   = Length;
        if (Length == '0) done_nxt  = 1'b1;
        else              state_nxt = STREAM;
      end
      STREAM: begin
        if (issue) begin
          addr_nxt  = addr + addr_t'(1);
          issue_nxt = issue_rem - len_t'(1);
        end
        if (fire) begin
          pop_nxt = pop_rem - len_t'(1);
          if (pop_rem == len_t'(1)) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (Abort) begin
      state_nxt = IDLE;
      issue_nxt = '0;
      pop_nxt   = '0;
      done_nxt  = 1'b0;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state     <= IDLE;
      addr      <= '0;
      issue_rem <= '0;
      pop_rem   <= '0;
      inflight  <= 1'b0;
      Done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      addr      <= addr_nxt;
      issue_rem <= issue_nxt;
      pop_rem   <= pop_nxt;
      inflight  <= issue && !Abort;
      Done      <= done_nxt;
    end
  end

  byte_prefetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .Clk       (Clk),
    .Reset     (Reset),
    .push      (inflight),
    .push_data (RamReadData),
    .pop       (fire),
    .flush     (Abort),
    .head      (OutData),
    .count     (fifo_count)
  );

`ifdef STREAM_READER_CRC_EN
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)       Crc16 <= '0;
    else if (accept) Crc16 <= '0;
    else if (fire)   Crc16 <= crc16_byte(Crc16, OutData);
  end
`endif
endmodule
